md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic [2:0]  op,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [31:0] MULT_LOAD = 32'(MULT_CYCLES);
  localparam logic [31:0] DIV_LOAD  = 32'(DIV_CYCLES);

  state_t      state, state_d;
  logic [31:0] cnt, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Arithmetic works only on captured operands so A/B may change during RUN.
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        b_zero;

  // Result datapath: signed ops go through magnitudes so the
  // 0x80000000 / -1 case wraps to 0x80000000 with remainder 0.
  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    a_zx   = {32'd0, a_q};
    b_zx   = {32'd0, b_q};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;
    b_zero = (b_q == 32'd0);
    a_mag  = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag  = b_q[31] ? (32'd0 - b_q) : b_q;
    q_mag  = 32'd0;
    r_mag  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (!b_zero) begin
      q_mag  = a_mag / b_mag;
      r_mag  = a_mag % b_mag;
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
    end
    quot_s = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    rem_s  = a_q[31] ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state logic: accept work in IDLE, count down in RUN, retire on cnt==1.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = A;
              b_d     = B;
              op_d    = op;
              cnt_d   = MULT_LOAD;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = A;
              b_d     = B;
              op_d    = op;
              cnt_d   = DIV_LOAD;
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is deliberately ignored here; the pipeline stalls on busy.
        cnt_d = cnt - 32'd1;
        if (cnt <= 32'd1) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (!b_zero) begin
                hi_d = rem_s;
                lo_d = quot_s;
              end
            end
            OP_DIVU: begin
              if (!b_zero) begin
                hi_d = rem_u;
                lo_d = quot_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over start and aborts any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 3'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign busy = (state == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
